// File: rtl/aes_core_stream_bridge_pkg.sv
// Shared definitions for the AES core stream bridge.
//   - default share count and stream word width
//   - helpers deriving word counts and counter widths from (d, W)
//   - state encodings of the input deserializer and output serializer FSMs
package aes_core_stream_bridge_pkg;

  localparam int NSHARES = 2;
  localparam int WORD_W  = 32;

  // Words per input transaction: key sharing followed by plaintext sharing.
  function automatic int calc_nw_in(input int d, input int w);
    return (256 * d) / w;
  endfunction

  // Words per output transaction: one ciphertext sharing.
  function automatic int calc_nw_out(input int d, input int w);
    return (128 * d) / w;
  endfunction

  function automatic int calc_in_cnt_w(input int d, input int w);
    return $clog2(calc_nw_in(d, w));
  endfunction

  function automatic int calc_out_cnt_w(input int d, input int w);
    return $clog2(calc_nw_out(d, w));
  endfunction

  typedef enum logic [1:0] {
    I_RST  = 2'd0,
    I_LOAD = 2'd1,
    I_FULL = 2'd2
  } in_state_t;

  typedef enum logic {
    O_EMPTY = 1'b0,
    O_DRAIN = 1'b1
  } out_state_t;

endpackage

// File: rtl/aes_core_stream_bridge_out_serializer.sv
// Output half of the bridge: captures one ciphertext sharing from the core
// and plays it out as a stream of W-bit words, lowest word first.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   core_cipher_valid   core offers a ciphertext sharing
//   core_out_ready      serializer can capture (high only while empty)
//   core_sh_ciphertext  ciphertext sharing from the core
//   out_data/out_valid/out_last/out_ready  outgoing word stream
//   dbg_state           current O_* state
// Handshake: a word or sharing moves on a rising edge where valid and ready
// are both high; a source holding valid keeps its data stable until then.
module aes_core_stream_bridge_out_serializer
  import aes_core_stream_bridge_pkg::*;
#(
  parameter int d = NSHARES,
  parameter int W = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_cipher_valid,
  output logic             core_out_ready,
  input  logic [128*d-1:0] core_sh_ciphertext,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             dbg_state
);

  localparam int NW_OUT = calc_nw_out(d, W);
  localparam int CW     = calc_out_cnt_w(d, W);
  localparam logic [CW-1:0] CNT_LAST = CW'(NW_OUT - 1);

  out_state_t       state;
  logic [128*d-1:0] buf_q;
  logic [CW-1:0]    out_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= O_EMPTY;
      buf_q          <= '0;
      out_cnt        <= '0;
      out_valid      <= 1'b0;
      core_out_ready <= 1'b0;
    end else begin
      case (state)
        O_EMPTY: begin
          if (core_cipher_valid && core_out_ready) begin
            buf_q          <= core_sh_ciphertext;
            out_cnt        <= '0;
            out_valid      <= 1'b1;
            core_out_ready <= 1'b0;
            state          <= O_DRAIN;
          end else begin
            // First cycle out of reset raises ready; afterwards it just holds.
            core_out_ready <= 1'b1;
          end
        end
        O_DRAIN: begin
          if (out_ready) begin
            if (out_cnt == CNT_LAST) begin
              // Scrub the sharing as soon as the last word has left.
              buf_q          <= '0;
              out_cnt        <= '0;
              out_valid      <= 1'b0;
              core_out_ready <= 1'b1;
              state          <= O_EMPTY;
            end else begin
              out_cnt <= out_cnt + CW'(1);
            end
          end
        end
        default: state <= O_EMPTY;
      endcase
    end
  end

  // Buffer is zero outside O_DRAIN, but gate anyway so idle data is always 0.
  assign out_data  = out_valid ? buf_q[W*int'(out_cnt) +: W] : '0;
  assign out_last  = out_valid & (out_cnt == CNT_LAST);
  assign dbg_state = state;

endmodule

// File: rtl/aes_core_stream_bridge.sv
// Host-side bridge for the masked AES core.
// Input side collects key sharing then plaintext sharing from a W-bit word
// stream and presents the complete sharing to the core; the output side
// (out_serializer) streams the ciphertext sharing back. The two sides are
// independent, so a new block can load while the previous result drains.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready    incoming word stream
//   out_data/out_valid/out_last/out_ready outgoing word stream
//   err_framing                    sticky, in_last on the wrong word
//   core_valid_in/core_in_ready    sharing hand-off to the core
//   core_sh_key/core_sh_plaintext  full sharings, zero unless complete
//   core_cipher_valid/core_out_ready/core_sh_ciphertext  result hand-off
//   dbg_in_state/dbg_out_state     FSM state observation
// Handshake: a word or sharing moves on a rising edge where valid and ready
// are both high; a source holding valid keeps its data stable until then.
module aes_core_stream_bridge
  import aes_core_stream_bridge_pkg::*;
#(
  parameter int d = NSHARES,
  parameter int W = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err_framing,
  output logic             core_valid_in,
  input  logic             core_in_ready,
  output logic [128*d-1:0] core_sh_key,
  output logic [128*d-1:0] core_sh_plaintext,
  input  logic             core_cipher_valid,
  output logic             core_out_ready,
  input  logic [128*d-1:0] core_sh_ciphertext,
  output logic [1:0]       dbg_in_state,
  output logic             dbg_out_state
);

  localparam int NW_IN = calc_nw_in(d, W);
  localparam int CW    = calc_in_cnt_w(d, W);
  localparam int SH_W  = 128 * d;
  localparam logic [CW-1:0] CNT_LAST = CW'(NW_IN - 1);

  in_state_t        state;
  // {plaintext sharing, key sharing}: word k lands at bit W*k, which puts
  // the first 128*d/W words in the key and the rest in the plaintext.
  logic [2*SH_W-1:0] in_buf;
  logic [CW-1:0]     in_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= I_RST;
      in_buf        <= '0;
      in_cnt        <= '0;
      in_ready      <= 1'b0;
      core_valid_in <= 1'b0;
      err_framing   <= 1'b0;
    end else begin
      case (state)
        I_RST: begin
          in_ready <= 1'b1;
          state    <= I_LOAD;
        end
        I_LOAD: begin
          if (in_valid && in_ready) begin
            if (in_last != (in_cnt == CNT_LAST)) begin
              // Misframed block: consume the word, drop everything so far.
              err_framing <= 1'b1;
              in_buf      <= '0;
              in_cnt      <= '0;
            end else if (in_last) begin
              in_buf[W*int'(in_cnt) +: W] <= in_data;
              in_ready      <= 1'b0;
              core_valid_in <= 1'b1;
              state         <= I_FULL;
            end else begin
              in_buf[W*int'(in_cnt) +: W] <= in_data;
              in_cnt <= in_cnt + CW'(1);
            end
          end
        end
        I_FULL: begin
          if (core_in_ready) begin
            in_buf        <= '0;
            in_cnt        <= '0;
            in_ready      <= 1'b1;
            core_valid_in <= 1'b0;
            state         <= I_LOAD;
          end
        end
        default: state <= I_RST;
      endcase
    end
  end

  // Only a complete sharing is ever visible to the core.
  assign core_sh_key       = (state == I_FULL) ? in_buf[SH_W-1:0]      : '0;
  assign core_sh_plaintext = (state == I_FULL) ? in_buf[2*SH_W-1:SH_W] : '0;
  assign dbg_in_state      = state;

  aes_core_stream_bridge_out_serializer #(
    .d(d),
    .W(W)
  ) u_ser (
    .clk                (clk),
    .rst                (rst),
    .core_cipher_valid  (core_cipher_valid),
    .core_out_ready     (core_out_ready),
    .core_sh_ciphertext (core_sh_ciphertext),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_last           (out_last),
    .out_ready          (out_ready),
    .dbg_state          (dbg_out_state)
  );

endmodule

// File: tb/tb_aes_core_stream_bridge.sv
// Bench for aes_core_stream_bridge with d=2, W=32 (16 words in, 8 words out).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A behavioural core model accepts sharings and returns a
// masked ciphertext; the bench compares unmasked values against a queue of
// expected results filled when each block is driven.
module tb_aes_core_stream_bridge;
  import aes_core_stream_bridge_pkg::*;

  localparam int D    = 2;
  localparam int W    = 32;
  localparam int SH_W = 128 * D;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic            err_framing;
  logic            core_valid_in;
  logic            core_in_ready = 1'b1;
  logic [SH_W-1:0] core_sh_key;
  logic [SH_W-1:0] core_sh_plaintext;
  logic            core_cipher_valid = 1'b0;
  logic            core_out_ready;
  logic [SH_W-1:0] core_sh_ciphertext = '0;
  logic [1:0]      dbg_in_state;
  logic            dbg_out_state;

  aes_core_stream_bridge #(.d(D), .W(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_last            (in_last),
    .in_ready           (in_ready),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_last           (out_last),
    .out_ready          (out_ready),
    .err_framing        (err_framing),
    .core_valid_in      (core_valid_in),
    .core_in_ready      (core_in_ready),
    .core_sh_key        (core_sh_key),
    .core_sh_plaintext  (core_sh_plaintext),
    .core_cipher_valid  (core_cipher_valid),
    .core_out_ready     (core_out_ready),
    .core_sh_ciphertext (core_sh_ciphertext),
    .dbg_in_state       (dbg_in_state),
    .dbg_out_state      (dbg_out_state)
  );

  // scoreboard
  int tests_run    = 0;
  int tests_failed = 0;
  logic [127:0] exp_q[$];      // expected unmasked ciphertext per block
  logic [255:0] exp_blk_q[$];  // expected unmasked {plaintext, key} at core
  logic [127:0] ct_q[$];       // core model results awaiting hand-back
  int blocks_done  = 0;
  int accepted_cnt = 0;
  int total_beats  = 0;
  int out_mode     = 0;        // 0: ready high, 1: random, 2: ready low

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_cipher(input logic [127:0] key,
                                              input logic [127:0] pt);
    if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
    return key ^ {pt[63:0], pt[127:64]} ^ 128'h5a5a_3c3c_0ff0_a5a5_1234_8765_c3c3_9696;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // driver tasks
  task automatic drive_beat(input logic [W-1:0] data, input logic last,
                            input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_block(input logic [127:0] key, input logic [127:0] pt,
                            input bit gaps);
    logic [127:0] rk, rp;
    logic [511:0] blk;
    rk  = rand128();
    rp  = rand128();
    blk = {pt ^ rp, rp, key ^ rk, rk};
    exp_blk_q.push_back({pt, key});
    exp_q.push_back(ref_cipher(key, pt));
    for (int k = 0; k < 16; k++) drive_beat(blk[32*k +: 32], k == 15, gaps);
    check("core_valid_in_after_last", core_valid_in, 1'b1);
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    while (blocks_done < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("blocks_done", blocks_done, n);
    @(posedge clk); #1;
  endtask

  // core model
  always begin : core_model
    logic acc, cap;
    logic [255:0] got, e;
    logic [127:0] r, ct;
    @(negedge clk);
    acc = rst && core_valid_in && core_in_ready;
    cap = rst && core_cipher_valid && core_out_ready;
    if (acc) begin
      got = {core_sh_plaintext[127:0] ^ core_sh_plaintext[255:128],
             core_sh_key[127:0] ^ core_sh_key[255:128]};
      check("core_issue_pending", exp_blk_q.size() != 0, 1'b1);
      if (exp_blk_q.size() != 0) begin
        e = exp_blk_q.pop_front();
        check("core_sharing", got, e);
      end
      accepted_cnt++;
      ct_q.push_back(ref_cipher(got[127:0], got[255:128]));
    end
    @(posedge clk); #1;
    if (cap) begin
      core_cipher_valid  = 1'b0;
      core_sh_ciphertext = '0;
    end
    if (!core_cipher_valid && ct_q.size() != 0) begin
      ct = ct_q.pop_front();
      r  = rand128();
      core_sh_ciphertext = {ct ^ r, r};
      core_cipher_valid  = 1'b1;
    end
  end

  // output monitor / sink
  always begin : out_monitor
    static int beat_cnt = 0;
    static logic prev_stall = 1'b0;
    static logic [W-1:0] prev_data = '0;
    static logic prev_last = 1'b0;
    static logic [255:0] got = '0;
    logic [127:0] e;
    @(negedge clk);
    if (!rst) begin
      beat_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        check("out_data_stable", out_data, prev_data);
        check("out_last_stable", out_last, prev_last);
      end
      if (!out_valid) check("out_data_idle_zero", out_data, '0);
      if (out_valid && out_ready) begin
        check("out_last", out_last, beat_cnt == 7);
        got[32*beat_cnt +: 32] = out_data;
        beat_cnt++;
        total_beats++;
        if (beat_cnt == 8) begin
          check("exp_q_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ciphertext", got[127:0] ^ got[255:128], e);
          end
          blocks_done++;
          beat_cnt = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    @(posedge clk); #1;
    case (out_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_err_framing"}, err_framing, 1'b0);
    check({tag, "_core_valid_in"}, core_valid_in, 1'b0);
    check({tag, "_core_out_ready"}, core_out_ready, 1'b0);
    check({tag, "_core_sh_key"}, core_sh_key, '0);
    check({tag, "_core_sh_pt"}, core_sh_plaintext, '0);
    check({tag, "_in_state"}, dbg_in_state, I_RST);
    check({tag, "_out_state"}, dbg_out_state, O_EMPTY);
    check({tag, "_in_buf"}, dut.in_buf, '0);
    check({tag, "_out_buf"}, dut.u_ser.buf_q, '0);
  endtask

  // directed sequence
  initial begin
    int c;
    int base;
    logic [SH_W-1:0] snap_key, snap_pt;

    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1'b1);
    check("in_state_after_release", dbg_in_state, I_LOAD);
    check("core_out_ready_after_release", core_out_ready, 1'b1);

    // nominal FIPS-197 block, back-to-back beats
    out_mode = 0;
    send_block(FIPS_KEY, FIPS_PT, 1'b0);
    wait_done(1);

    // backpressure on both sides
    out_mode = 1;
    send_block(rand128(), rand128(), 1'b1);
    wait_done(2);
    out_mode = 0;

    // framing error: in_last on beat 5
    for (int k = 0; k < 5; k++) drive_beat($urandom(), k == 4, 1'b0);
    check("framing_err", err_framing, 1'b1);
    check("framing_no_issue", core_valid_in, 1'b0);
    check("framing_in_ready", in_ready, 1'b1);
    check("framing_in_buf_zero", dut.in_buf, '0);
    send_block(rand128(), rand128(), 1'b0);
    wait_done(3);
    check("framing_err_sticky", err_framing, 1'b1);

    // overlap: block 2 loads and issues while block 1 is stuck draining
    out_mode = 2;
    base = accepted_cnt;
    send_block(rand128(), rand128(), 1'b0);
    c = 0;
    while (!out_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("overlap_drain_started", out_valid, 1'b1);
    check("overlap_core_out_ready_low", core_out_ready, 1'b0);
    @(posedge clk); #1;
    send_block(rand128(), rand128(), 1'b1);
    c = 0;
    while (accepted_cnt < base + 2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("overlap_block2_issued", accepted_cnt, base + 2);
    check("overlap_core_out_ready_still_low", core_out_ready, 1'b0);
    check("overlap_out_state", dbg_out_state, O_DRAIN);
    base = total_beats;
    out_mode = 0;
    c = 0;
    @(negedge clk);
    while (!core_out_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("overlap_beats_before_ready", total_beats - base, 8);
    wait_done(5);

    // reset mid-transaction after beat 9
    for (int k = 0; k < 9; k++) drive_beat($urandom(), 1'b0, 1'b0);
    check("pre_reset_err_sticky", err_framing, 1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("midreset_hold");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_midreset", in_ready, 1'b1);
    send_block(rand128(), rand128(), 1'b1);
    wait_done(6);

    // core stall for 50 cycles
    core_in_ready = 1'b0;
    send_block(rand128(), rand128(), 1'b0);
    snap_key = core_sh_key;
    snap_pt  = core_sh_plaintext;
    repeat (50) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_core_valid_in", core_valid_in, 1'b1);
      check("stall_key_stable", core_sh_key, snap_key);
      check("stall_pt_stable", core_sh_plaintext, snap_pt);
    end
    @(posedge clk); #1;
    core_in_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_in_buf_zero", dut.in_buf, '0);
    check("handoff_core_sh_key_zero", core_sh_key, '0);
    check("handoff_core_valid_in", core_valid_in, 1'b0);
    check("handoff_in_ready", in_ready, 1'b1);
    wait_done(7);

    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_exp_blk_q_empty", exp_blk_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
